// File: rtl/func_gen_pkg.sv
// Shared types, constants and helpers for the function generator output chain.
// Samples are unsigned 8-bit with the waveform centred on MIDSCALE.
package func_gen_pkg;

   typedef logic [7:0] signal_t;

   localparam signal_t    MIDSCALE   = 8'd128;
   localparam logic [7:0] UNITY_GAIN = 8'd128;

   function automatic signal_t sat_u8(input logic signed [10:0] v);
      if (v < 11'sd0)
         return 8'd0;
      else if (v > 11'sd255)
         return 8'd255;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/wave_dac_out_if.sv
// Sample/control bundle between the function generator and its DAC output stage.
// The master side drives the waveform and settings; the slave side returns the DAC outputs.
interface wave_dac_out_if;
   import func_gen_pkg::*;

   logic       enable;
   signal_t    signal_in;
   logic [7:0] gain;
   logic [7:0] offset;
   signal_t    sample_out;
   logic       pwm_out;
   logic       period_start;

   modport master (
      output enable, signal_in, gain, offset,
      input  sample_out, pwm_out, period_start
   );

   modport slave (
      input  enable, signal_in, gain, offset,
      output sample_out, pwm_out, period_start
   );

endinterface

// File: rtl/pwm_dac_core.sv
// 8-bit PWM DAC: prescaler, period counter, period-aligned duty latch and output register.
// Duty is only taken at the 255->0 wrap so a period never shows a truncated pulse.
module pwm_dac_core #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] duty,
   output logic       pwm_out,
   output logic       period_start
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0] pre;
   logic [7:0]    cnt;
   logic [7:0]    duty_lat;
   logic          tick;

   assign tick = (pre == PW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre          <= '0;
         cnt          <= 8'd0;
         duty_lat     <= 8'd0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else if (!enable) begin
         // Parked: the latch tracks the sample so re-enable starts on the current value.
         pre          <= '0;
         cnt          <= 8'd0;
         duty_lat     <= duty;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         pre          <= tick ? '0 : pre + PW'(1);
         if (tick)
            cnt <= cnt + 8'd1;
         if (tick && (cnt == 8'd255))
            duty_lat <= duty;
         pwm_out      <= (cnt < duty_lat);
         period_start <= tick && (cnt == 8'd0);
      end
   end

endmodule

// File: rtl/wave_dac_out.sv
// Waveform output stage: two-stage gain/offset/saturate pipeline feeding the PWM DAC core.
// The datapath runs continuously; enable only gates the PWM side.
module wave_dac_out
   import func_gen_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input logic           clk,
   input logic           rst_n,
   wave_dac_out_if.slave bus
);

   signal_t           sig_r;
   logic [7:0]        gain_r;
   logic signed [7:0] off_r;
   signal_t           sample_r;

   logic signed [8:0]  c;
   logic signed [17:0] p;
   logic signed [10:0] s;

   // Gain is Q1.7, so >>>7 rescales; arithmetic shift floors negative products.
   always_comb begin
      c = $signed({1'b0, sig_r}) - $signed({1'b0, MIDSCALE});
      p = c * $signed({1'b0, gain_r});
      s = 11'(p >>> 7) + $signed({3'b000, MIDSCALE}) + 11'(off_r);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_r    <= 8'd0;
         gain_r   <= 8'd0;
         off_r    <= 8'sd0;
         sample_r <= 8'd0;
      end else begin
         sig_r    <= bus.signal_in;
         gain_r   <= bus.gain;
         off_r    <= $signed(bus.offset);
         sample_r <= sat_u8(s);
      end
   end

   assign bus.sample_out = sample_r;

   pwm_dac_core #(
      .CLK_DIV (CLK_DIV)
   ) u_core (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (bus.enable),
      .duty         (sample_r),
      .pwm_out      (bus.pwm_out),
      .period_start (bus.period_start)
   );

endmodule

// File: tb/tb_wave_dac_out.sv
// Bench for wave_dac_out: vector table and random stream for the scale pipeline,
// period-level high-time counts for the PWM side, plus enable and reset sequences.
module tb_wave_dac_out;
   import func_gen_pkg::*;

   localparam int CD    = 2;
   localparam int PER   = 256 * CD;
   localparam int LIMIT = 4 * PER;
   localparam int NRAND = 300;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wave_dac_out_if bus();

   wave_dac_out #(.CLK_DIV(CD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      int sig;
      int gain;
      int off;
      int exp;
   } vec_t;

   vec_t vecs[$];
   int   es[NRAND];

   // Reference: real-valued scale with floor division, then clamp.
   function automatic int ref_sample(input int sig, input int gain, input int off);
      int c, p, q, s;
      c = sig - 128;
      p = c * gain;
      if (p >= 0) q = p / 128;
      else        q = -((-p + 127) / 128);
      s = q + 128 + off;
      if (s < 0)   return 0;
      if (s > 255) return 255;
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int sig, input int gain, input int off);
      bus.signal_in = 8'(sig);
      bus.gain      = 8'(gain);
      bus.offset    = 8'(off);
   endtask

   task automatic wait_ps(input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < LIMIT && !seen; n++) begin
         step();
         seen = bus.period_start;
      end
      check({name, "_ps_seen"}, int'(seen), 1);
   endtask

   // Starts on a period_start cycle; counts high clks up to the next period_start.
   task automatic count_period(input int change_at, input int new_sig,
                               output int high, output int len);
      high = 0;
      len  = 0;
      do begin
         high += int'(bus.pwm_out);
         if (len == change_at) bus.signal_in = 8'(new_sig);
         len++;
         step();
      end while (!bus.period_start && len < LIMIT);
   endtask

   task automatic pwm_case(input string name, input int sig, input int exp_high);
      int h, l;
      drive(sig, 128, 0);
      wait_ps(name);
      wait_ps(name);
      count_period(-1, 0, h, l);
      check({name, "_high"}, h, exp_high);
      check({name, "_len"}, l, PER);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int h, l, n, quiet, d, r_sig, r_gain, r_off;

      bus.enable = 1'b0;
      drive(0, 0, 0);
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_sample", int'(bus.sample_out), 0);
      check("rst_pwm", int'(bus.pwm_out), 0);
      check("rst_ps", int'(bus.period_start), 0);
      rst_n = 1'b1;

      vecs.push_back('{200, 128,    0, 200});
      vecs.push_back('{255, 255,    0, 255});
      vecs.push_back('{  0, 255,    0,   0});
      vecs.push_back('{  0,  64,    0,  64});
      vecs.push_back('{128, 128, -100,  28});
      vecs.push_back('{ 77,   0,    0, 128});
      vecs.push_back('{127,   1,    0, 127});
      vecs.push_back('{129,   3,    0, 128});
      vecs.push_back('{ 60, 200,   30,  51});
      vecs.push_back('{200, 128,  100, 255});
      vecs.push_back('{ 10, 128,  -20,   0});
      vecs.push_back('{  0, 128,  127, 127});
      vecs.push_back('{128, 255,  127, 255});

      foreach (vecs[i]) begin
         drive(vecs[i].sig, vecs[i].gain, vecs[i].off);
         step();
         step();
         check($sformatf("vec%0d", i), int'(bus.sample_out), vecs[i].exp);
      end

      for (int i = 0; i < NRAND; i++) begin
         if (i >= 2) check($sformatf("rand%0d", i - 2), int'(bus.sample_out), es[i - 2]);
         r_sig  = int'($urandom_range(0, 255));
         r_gain = int'($urandom_range(0, 255));
         r_off  = int'($urandom_range(0, 255)) - 128;
         es[i]  = ref_sample(r_sig, r_gain, r_off);
         drive(r_sig, r_gain, r_off);
         step();
      end

      bus.enable = 1'b1;
      pwm_case("unity", 200, 200 * CD);
      repeat (3) begin
         d = int'($urandom_range(1, 254));
         pwm_case($sformatf("duty%0d", d), d, d * CD);
      end
      pwm_case("duty0", 0, 0);
      pwm_case("duty255", 255, 255 * CD);

      drive(50, 128, 0);
      wait_ps("glitch");
      wait_ps("glitch");
      count_period(10 * CD, 150, h, l);
      check("glitch_cur_high", h, 50 * CD);
      check("glitch_cur_len", l, PER);
      count_period(-1, 0, h, l);
      check("glitch_next_high", h, 150 * CD);
      check("glitch_next_len", l, PER);

      drive(100, 128, 0);
      wait_ps("en");
      wait_ps("en");
      repeat (30 * CD) step();
      check("en_pwm_before", int'(bus.pwm_out), 1);
      bus.enable = 1'b0;
      step();
      check("en_off_pwm", int'(bus.pwm_out), 0);
      check("en_off_cnt", int'(dut.u_core.cnt), 0);
      drive(60, 128, 0);
      quiet = 0;
      repeat (20) begin
         step();
         quiet += int'(bus.pwm_out) + int'(bus.period_start);
      end
      check("en_off_quiet", quiet, 0);
      bus.enable = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.period_start && n < LIMIT);
      check("reen_latency", n, CD);
      count_period(-1, 0, h, l);
      check("reen_high", h, 60 * CD);
      check("reen_len", l, PER);

      drive(200, 128, 0);
      wait_ps("rst");
      wait_ps("rst");
      repeat (120 * CD) step();
      check("rst_mid_pwm_before", int'(bus.pwm_out), 1);
      rst_n = 1'b0;
      step();
      check("rst_mid_pwm", int'(bus.pwm_out), 0);
      check("rst_mid_sample", int'(bus.sample_out), 0);
      check("rst_mid_cnt", int'(dut.u_core.cnt), 0);
      check("rst_mid_ps", int'(bus.period_start), 0);
      rst_n = 1'b1;
      step();
      step();
      check("rst_resume_sample", int'(bus.sample_out), 200);
      wait_ps("rst_resume");
      wait_ps("rst_resume");
      count_period(-1, 0, h, l);
      check("rst_resume_high", h, 200 * CD);
      check("rst_resume_len", l, PER);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
